// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the multi-channel a->b implication monitor.
// The state encoding is visible on the state output, so its values are fixed.
package seq_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    ACTIVE = 2'd2,
    HALTED = 2'd3
  } chk_state_e;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // Add and clamp to the all-ones value of a counter 'width' bits wide (1..32).
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input int unsigned width);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (33'd1 << width) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/seq_history_checker_if.sv
// Signal bundle between the monitored datapath (master) and the checker (slave).
interface seq_history_checker_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int TS_W   = 32
);
  import seq_chk_pkg::*;

  localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              enable;
  logic              clear;
  logic [NUM_CH-1:0] a;
  logic [NUM_CH-1:0] b;
  logic [NUM_CH-1:0] fail_pulse;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              err_sticky;
  logic [FCH_W-1:0]  first_fail_ch;
  logic [TS_W-1:0]   first_fail_ts;
  chk_state_e        state;

  modport master (
    output enable, clear, a, b,
    input  fail_pulse, pass_cnt, fail_cnt, err_sticky,
           first_fail_ch, first_fail_ts, state
  );

  modport slave (
    input  enable, clear, a, b,
    output fail_pulse, pass_cnt, fail_cnt, err_sticky,
           first_fail_ch, first_fail_ts, state
  );

endinterface

// File: rtl/seq_history_checker_hist_window.sv
// Per-channel history of sampled 'a'; hit is high when any entry in the
// DELAY_MIN..DELAY_MAX window was set. Bit j holds 'a' from j+1 cycles ago.
module hist_window #(
  parameter int DELAY_MIN = 2,
  parameter int DELAY_MAX = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic a_in,
  output logic hit
);

  logic [DELAY_MAX-1:0] hist;

  generate
    if (DELAY_MAX == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist <= '0;
        end else begin
          hist <= flush ? 1'b0 : a_in;
        end
      end
    end else begin : g_deep
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist <= '0;
        end else if (flush) begin
          hist <= '0;
        end else begin
          hist <= {hist[DELAY_MAX-2:0], a_in};
        end
      end
    end
  endgenerate

  // Dropping the entries nearer than DELAY_MIN leaves exactly the window.
  assign hit = |(hist >> (DELAY_MIN - 1));

endmodule

// File: rtl/seq_history_checker.sv
// N-channel "b implies a within DELAY_MIN..DELAY_MAX cycles earlier" monitor
// with saturating statistics, sticky error and first-failure capture.
//
// state  | meaning
// IDLE   | enable low, history held at zero
// WARMUP | history filling, b ignored for DELAY_MAX cycles
// ACTIVE | every b is checked against the history window
// HALTED | stopped after a failure (STOP_ON_FAIL), waits for clear
module seq_history_checker
  import seq_chk_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DELAY_MIN    = 2,
  parameter int DELAY_MAX    = 2,
  parameter int CNT_W        = 16,
  parameter int TS_W         = 32,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_history_checker_if.slave bus
);

  localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WU_W  = $clog2(DELAY_MAX + 1);

  chk_state_e        state_q, state_d;
  logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] pass_vec;
  logic [NUM_CH-1:0] fail_vec;
  logic              flush;
  logic              check_en;
  logic              any_fail;
  logic [FCH_W-1:0]  low_fail_ch;

  logic [TS_W-1:0]   ts_q;
  logic [CNT_W-1:0]  pass_cnt_q;
  logic [CNT_W-1:0]  fail_cnt_q;
  logic [NUM_CH-1:0] fail_pulse_q;
  logic              err_sticky_q;
  logic [FCH_W-1:0]  ff_ch_q;
  logic [TS_W-1:0]   ff_ts_q;

  assign flush = !bus.enable || (state_q == IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hist_window #(
      .DELAY_MIN (DELAY_MIN),
      .DELAY_MAX (DELAY_MAX)
    ) u_hist (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .a_in  (bus.a[i]),
      .hit   (hit[i])
    );
  end

  // A clear in the same cycle throws the check away entirely, so it also
  // cannot trigger a halt.
  assign check_en = bus.enable && (state_q == ACTIVE) && !bus.clear;
  assign pass_vec = check_en ? (bus.b & hit)  : '0;
  assign fail_vec = check_en ? (bus.b & ~hit) : '0;
  assign any_fail = |fail_vec;

  always_comb begin
    low_fail_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_vec[i]) low_fail_ch = FCH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wu_cnt_q <= wu_cnt_d;
    end
  end

  // Warm-up is a down-counter loaded with DELAY_MAX-1; terminal count moves to ACTIVE.
  always_comb begin
    state_d  = state_q;
    wu_cnt_d = wu_cnt_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = WARMUP;
          wu_cnt_d = WU_W'(DELAY_MAX - 1);
        end
        WARMUP: begin
          if (wu_cnt_q == '0) state_d = ACTIVE;
          else                wu_cnt_d = wu_cnt_q - WU_W'(1);
        end
        ACTIVE: begin
          if (STOP_ON_FAIL && any_fail) state_d = HALTED;
        end
        HALTED: begin
          if (bus.clear) begin
            state_d  = WARMUP;
            wu_cnt_d = WU_W'(DELAY_MAX - 1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q         <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      fail_pulse_q <= '0;
      err_sticky_q <= 1'b0;
      ff_ch_q      <= '0;
      ff_ts_q      <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (bus.clear) begin
        pass_cnt_q   <= '0;
        fail_cnt_q   <= '0;
        fail_pulse_q <= '0;
        err_sticky_q <= 1'b0;
        ff_ch_q      <= '0;
        ff_ts_q      <= '0;
      end else begin
        fail_pulse_q <= fail_vec;
        pass_cnt_q   <= CNT_W'(sat_add(32'(pass_cnt_q), popcount(32'(pass_vec)), CNT_W));
        fail_cnt_q   <= CNT_W'(sat_add(32'(fail_cnt_q), popcount(32'(fail_vec)), CNT_W));
        if (any_fail) err_sticky_q <= 1'b1;
        if (any_fail && !err_sticky_q) begin
          ff_ch_q <= low_fail_ch;
          ff_ts_q <= ts_q;
        end
      end
    end
  end

  assign bus.fail_pulse    = fail_pulse_q;
  assign bus.pass_cnt      = pass_cnt_q;
  assign bus.fail_cnt      = fail_cnt_q;
  assign bus.err_sticky    = err_sticky_q;
  assign bus.first_fail_ch = ff_ch_q;
  assign bus.first_fail_ts = ff_ts_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_seq_history_checker.sv
// Two checkers (window 2..2 / 16-bit counters, and window 2..4 / 4-bit counters
// with halt-on-fail) share one stimulus stream and are compared to a cycle-log model.
module tb_seq_history_checker;
  import seq_chk_pkg::*;

  localparam int LOGN = 8192;

  logic clk;
  logic rst_n;
  logic en, clr;
  logic [3:0] a_in, b_in;

  int nchk = 0;
  int nerr = 0;

  seq_history_checker_if #(.NUM_CH(4), .CNT_W(16), .TS_W(32)) bus0 ();
  seq_history_checker_if #(.NUM_CH(4), .CNT_W(4),  .TS_W(32)) bus1 ();

  assign bus0.enable = en;
  assign bus0.clear  = clr;
  assign bus0.a      = a_in;
  assign bus0.b      = b_in;
  assign bus1.enable = en;
  assign bus1.clear  = clr;
  assign bus1.a      = a_in;
  assign bus1.b      = b_in;

  seq_history_checker #(
    .NUM_CH(4), .DELAY_MIN(2), .DELAY_MAX(2), .CNT_W(16), .TS_W(32), .STOP_ON_FAIL(1'b0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  seq_history_checker #(
    .NUM_CH(4), .DELAY_MIN(2), .DELAY_MAX(4), .CNT_W(4), .TS_W(32), .STOP_ON_FAIL(1'b1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [3:0]  o_pul [2];
  logic [31:0] o_pc  [2];
  logic [31:0] o_fc  [2];
  logic [31:0] o_ts  [2];
  logic        o_stk [2];
  logic [1:0]  o_ffc [2];
  logic [1:0]  o_st  [2];

  assign o_pul[0] = bus0.fail_pulse;
  assign o_pul[1] = bus1.fail_pulse;
  assign o_pc[0]  = 32'(bus0.pass_cnt);
  assign o_pc[1]  = 32'(bus1.pass_cnt);
  assign o_fc[0]  = 32'(bus0.fail_cnt);
  assign o_fc[1]  = 32'(bus1.fail_cnt);
  assign o_ts[0]  = bus0.first_fail_ts;
  assign o_ts[1]  = bus1.first_fail_ts;
  assign o_stk[0] = bus0.err_sticky;
  assign o_stk[1] = bus1.err_sticky;
  assign o_ffc[0] = bus0.first_fail_ch;
  assign o_ffc[1] = bus1.first_fail_ch;
  assign o_st[0]  = bus0.state;
  assign o_st[1]  = bus1.state;

  // Reference model: a log of every sampled 'a' by cycle number, plus the
  // first cycle whose 'a' is still remembered after the last flush.
  int m_dmin [2] = '{2, 2};
  int m_dmax [2] = '{2, 4};
  int m_max  [2] = '{65535, 15};
  int m_stop [2] = '{0, 1};

  logic [3:0] a_log [LOGN];
  int         cyc;
  int         m_st    [2];
  int         m_warm  [2];
  int         m_vfrom [2];
  int         m_pc    [2];
  int         m_fc    [2];
  bit         m_stk   [2];
  int         m_ffc   [2];
  int         m_ffts  [2];
  logic [3:0] m_pul   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0; m_warm[d] = 0; m_vfrom[d] = 0;
      m_pc[d] = 0; m_fc[d] = 0; m_stk[d] = 1'b0;
      m_ffc[d] = 0; m_ffts[d] = 0; m_pul[d] = '0;
    end
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0; a_in = '0; b_in = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle, advance the model across the posedge, sample 1 unit later.
  task automatic step(input logic e, input logic c, input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] fv, pv;
    bit hit;
    en = e; clr = c; a_in = av; b_in = bv;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      fv = '0; pv = '0;
      if (e && !c && m_st[d] == 2) begin
        for (int ch = 0; ch < 4; ch++) begin
          if (bv[ch]) begin
            hit = 1'b0;
            for (int k = m_dmin[d]; k <= m_dmax[d]; k++) begin
              if (cyc - k >= m_vfrom[d] && a_log[(cyc - k) % LOGN][ch]) hit = 1'b1;
            end
            if (hit) pv[ch] = 1'b1;
            else     fv[ch] = 1'b1;
          end
        end
      end
      if (c) begin
        m_pc[d] = 0; m_fc[d] = 0; m_stk[d] = 1'b0;
        m_ffc[d] = 0; m_ffts[d] = 0; m_pul[d] = '0;
      end else begin
        m_pul[d] = fv;
        m_pc[d] = (m_pc[d] + $countones(pv) > m_max[d]) ? m_max[d] : m_pc[d] + $countones(pv);
        m_fc[d] = (m_fc[d] + $countones(fv) > m_max[d]) ? m_max[d] : m_fc[d] + $countones(fv);
        if (fv != 4'd0 && !m_stk[d]) begin
          m_ffts[d] = cyc;
          for (int i = 3; i >= 0; i--) if (fv[i]) m_ffc[d] = i;
        end
        if (fv != 4'd0) m_stk[d] = 1'b1;
      end
      if (!e || m_st[d] == 0) m_vfrom[d] = cyc + 1;
      if (!e) begin
        m_st[d] = 0;
      end else if (m_st[d] == 0) begin
        m_st[d] = 1; m_warm[d] = m_dmax[d];
      end else if (m_st[d] == 1) begin
        m_warm[d] = m_warm[d] - 1;
        if (m_warm[d] == 0) m_st[d] = 2;
      end else if (m_st[d] == 2) begin
        if (m_stop[d] != 0 && fv != 4'd0) m_st[d] = 3;
      end else if (c) begin
        m_st[d] = 1; m_warm[d] = m_dmax[d];
      end
    end
    a_log[cyc % LOGN] = av;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      nchk++; if (o_pul[d] !== 4'd0) begin nerr++; $display("FAIL reset_pulse dut%0d got=%0h exp=0", d, o_pul[d]); end
      nchk++; if (o_pc[d] !== 32'd0) begin nerr++; $display("FAIL reset_pass_cnt dut%0d got=%0d exp=0", d, o_pc[d]); end
      nchk++; if (o_fc[d] !== 32'd0) begin nerr++; $display("FAIL reset_fail_cnt dut%0d got=%0d exp=0", d, o_fc[d]); end
      nchk++; if (o_stk[d] !== 1'b0) begin nerr++; $display("FAIL reset_sticky dut%0d got=%0b exp=0", d, o_stk[d]); end
      nchk++; if (o_ffc[d] !== 2'd0 || o_ts[d] !== 32'd0) begin nerr++; $display("FAIL reset_capture dut%0d got=%0d/%0d exp=0/0", d, o_ffc[d], o_ts[d]); end
      nchk++; if (o_st[d] !== 2'(IDLE)) begin nerr++; $display("FAIL reset_state dut%0d got=%0d exp=0", d, o_st[d]); end
    end
  endtask

  task automatic test_pass_fail();
    int exp_ts;
    do_reset();
    repeat (6) step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'b0001, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'b0001);
    nchk++; if (o_pc[0] !== 32'd1 || o_fc[0] !== 32'd0) begin nerr++; $display("FAIL pf_pass dut0 got=%0d/%0d exp=1/0", o_pc[0], o_fc[0]); end
    nchk++; if (o_pul[0] !== 4'd0) begin nerr++; $display("FAIL pf_no_pulse dut0 got=%0h exp=0", o_pul[0]); end
    nchk++; if (o_pc[1] !== 32'd1) begin nerr++; $display("FAIL pf_pass dut1 got=%0d exp=1", o_pc[1]); end
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'b0001, 4'd0);
    exp_ts = cyc;
    step(1'b1, 1'b0, 4'd0, 4'b0001);
    nchk++; if (o_pul[0] !== 4'b0001) begin nerr++; $display("FAIL pf_fail_pulse dut0 got=%0h exp=1", o_pul[0]); end
    nchk++; if (o_fc[0] !== 32'd1 || o_stk[0] !== 1'b1) begin nerr++; $display("FAIL pf_fail_cnt dut0 got=%0d/%0b exp=1/1", o_fc[0], o_stk[0]); end
    nchk++; if (o_ts[0] !== 32'(exp_ts) || o_ffc[0] !== 2'd0) begin nerr++; $display("FAIL pf_capture dut0 got=%0d/%0d exp=%0d/0", o_ts[0], o_ffc[0], exp_ts); end
    nchk++; if (o_st[1] !== 2'(HALTED)) begin nerr++; $display("FAIL pf_halt dut1 got=%0d exp=3", o_st[1]); end
    step(1'b1, 1'b0, 4'd0, 4'd0);
    nchk++; if (o_pul[0] !== 4'd0) begin nerr++; $display("FAIL pf_pulse_width dut0 got=%0h exp=0", o_pul[0]); end
  endtask

  task automatic test_halt_clear();
    int keep_ts;
    keep_ts = int'(o_ts[0]);
    repeat (3) step(1'b1, 1'b0, 4'd0, 4'b1111);
    nchk++; if (o_fc[1] !== 32'd1 || o_st[1] !== 2'(HALTED)) begin nerr++; $display("FAIL halt_hold dut1 got=%0d/%0d exp=1/3", o_fc[1], o_st[1]); end
    nchk++; if (o_fc[0] !== 32'd13) begin nerr++; $display("FAIL halt_nostop dut0 got=%0d exp=13", o_fc[0]); end
    nchk++; if (o_ts[0] !== 32'(keep_ts)) begin nerr++; $display("FAIL first_only dut0 got=%0d exp=%0d", o_ts[0], keep_ts); end
    step(1'b1, 1'b1, 4'd0, 4'd0);
    nchk++; if (o_st[1] !== 2'(WARMUP)) begin nerr++; $display("FAIL clear_rearm dut1 got=%0d exp=1", o_st[1]); end
    for (int d = 0; d < 2; d++) begin
      nchk++; if (o_pc[d] !== 32'd0 || o_fc[d] !== 32'd0 || o_stk[d] !== 1'b0) begin nerr++; $display("FAIL clear_zero dut%0d got=%0d/%0d/%0b exp=0/0/0", d, o_pc[d], o_fc[d], o_stk[d]); end
    end
  endtask

  task automatic test_window_multi();
    do_reset();
    repeat (6) step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'b0001, 4'd0);
    repeat (3) step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'b1011);
    nchk++; if (o_fc[1] !== 32'd2 || o_pc[1] !== 32'd1) begin nerr++; $display("FAIL win_cnt dut1 got=%0d/%0d exp=2/1", o_fc[1], o_pc[1]); end
    nchk++; if (o_ffc[1] !== 2'd1 || o_pul[1] !== 4'b1010) begin nerr++; $display("FAIL win_first dut1 got=%0d/%0h exp=1/a", o_ffc[1], o_pul[1]); end
    nchk++; if (o_fc[0] !== 32'd3 || o_ffc[0] !== 2'd0 || o_pul[0] !== 4'b1011) begin nerr++; $display("FAIL win_narrow dut0 got=%0d/%0d/%0h exp=3/0/b", o_fc[0], o_ffc[0], o_pul[0]); end
  endtask

  task automatic test_warmup();
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      step(1'b1, 1'b0, 4'hF, 4'hF);
      for (int d = 0; d < 2; d++) begin
        if (i <= m_dmax[d]) begin
          nchk++; if (o_pc[d] !== 32'd0 || o_pul[d] !== 4'd0) begin nerr++; $display("FAIL warm_ignored dut%0d i=%0d got=%0d/%0h exp=0/0", d, i, o_pc[d], o_pul[d]); end
        end
        if (i == m_dmax[d] + 1) begin
          nchk++; if (o_pc[d] !== 32'd4) begin nerr++; $display("FAIL warm_first_check dut%0d got=%0d exp=4", d, o_pc[d]); end
        end
        nchk++; if (o_st[d] !== 2'((i < m_dmax[d]) ? 1 : 2)) begin nerr++; $display("FAIL warm_state dut%0d i=%0d got=%0d exp=%0d", d, i, o_st[d], (i < m_dmax[d]) ? 1 : 2); end
      end
    end
  endtask

  task automatic test_saturation();
    repeat (5) step(1'b1, 1'b0, 4'hF, 4'hF);
    nchk++; if (o_pc[1] !== 32'd15) begin nerr++; $display("FAIL sat_pass dut1 got=%0d exp=15", o_pc[1]); end
    nchk++; if (o_pc[0] !== 32'd32) begin nerr++; $display("FAIL sat_pass dut0 got=%0d exp=32", o_pc[0]); end
    repeat (3) step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b1, 4'd0, 4'hF);
    for (int d = 0; d < 2; d++) begin
      nchk++; if (o_pc[d] !== 32'd0 || o_fc[d] !== 32'd0 || o_pul[d] !== 4'd0) begin nerr++; $display("FAIL clear_wins dut%0d got=%0d/%0d/%0h exp=0/0/0", d, o_pc[d], o_fc[d], o_pul[d]); end
    end
    nchk++; if (o_st[1] !== 2'(ACTIVE)) begin nerr++; $display("FAIL clear_no_halt dut1 got=%0d exp=2", o_st[1]); end
    step(1'b1, 1'b0, 4'd0, 4'hF);
    nchk++; if (o_fc[0] !== 32'd4 || o_fc[1] !== 32'd4 || o_st[1] !== 2'(HALTED)) begin nerr++; $display("FAIL after_clear got=%0d/%0d/%0d exp=4/4/3", o_fc[0], o_fc[1], o_st[1]); end
  endtask

  task automatic test_disable();
    step(1'b0, 1'b0, 4'hF, 4'hF);
    step(1'b0, 1'b0, 4'hF, 4'hF);
    for (int d = 0; d < 2; d++) begin
      nchk++; if (o_st[d] !== 2'(IDLE) || o_fc[d] !== 32'd4 || o_stk[d] !== 1'b1 || o_pul[d] !== 4'd0) begin nerr++; $display("FAIL disable_keep dut%0d got=%0d/%0d/%0b/%0h exp=0/4/1/0", d, o_st[d], o_fc[d], o_stk[d], o_pul[d]); end
    end
    step(1'b1, 1'b0, 4'd0, 4'd0);
    nchk++; if (o_st[0] !== 2'(WARMUP)) begin nerr++; $display("FAIL reenable dut0 got=%0d exp=1", o_st[0]); end
  endtask

  task automatic test_reset_mid();
    repeat (6) step(1'b1, 1'b0, 4'hF, 4'hF);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      nchk++; if (o_pc[d] !== 32'd0 || o_fc[d] !== 32'd0 || o_pul[d] !== 4'd0 || o_st[d] !== 2'(IDLE) || o_stk[d] !== 1'b0) begin nerr++; $display("FAIL mid_reset dut%0d got=%0d/%0d/%0h/%0d/%0b exp=0", d, o_pc[d], o_fc[d], o_pul[d], o_st[d], o_stk[d]); end
    end
    do_reset();
  endtask

  task automatic test_random(input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      logic e, c;
      logic [3:0] av, bv;
      e  = ($urandom_range(99) >= 2);
      c  = ($urandom_range(99) < 3);
      av = 4'($urandom) & 4'($urandom);
      bv = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step(e, c, av, bv);
      for (int d = 0; d < 2; d++) begin
        nchk++; if (o_pul[d] !== m_pul[d]) begin nerr++; $display("FAIL rnd_pulse dut%0d cyc=%0d got=%0h exp=%0h", d, cyc, o_pul[d], m_pul[d]); end
        nchk++; if (o_pc[d] !== 32'(m_pc[d])) begin nerr++; $display("FAIL rnd_pass_cnt dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, o_pc[d], m_pc[d]); end
        nchk++; if (o_fc[d] !== 32'(m_fc[d])) begin nerr++; $display("FAIL rnd_fail_cnt dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, o_fc[d], m_fc[d]); end
        nchk++; if (o_stk[d] !== m_stk[d]) begin nerr++; $display("FAIL rnd_sticky dut%0d cyc=%0d got=%0b exp=%0b", d, cyc, o_stk[d], m_stk[d]); end
        nchk++; if (o_ffc[d] !== 2'(m_ffc[d])) begin nerr++; $display("FAIL rnd_first_ch dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, o_ffc[d], m_ffc[d]); end
        nchk++; if (o_ts[d] !== 32'(m_ffts[d])) begin nerr++; $display("FAIL rnd_first_ts dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, o_ts[d], m_ffts[d]); end
        nchk++; if (o_st[d] !== 2'(m_st[d])) begin nerr++; $display("FAIL rnd_state dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, o_st[d], m_st[d]); end
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_pass_fail();
    test_halt_clear();
    test_window_multi();
    test_warmup();
    test_saturation();
    test_disable();
    test_reset_mid();
    test_random(1500);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
